// File: rtl/fsb_cycle_ctrl.sv
// fsb_cycle_ctrl: 68000 front-side-bus cycle phase tracking and DTACK/VPA termination
module fsb_cycle_ctrl (
  input  logic FCLK,
  input  logic RST,
  input  logic nAS,
  input  logic Ready,
  input  logic IACS,
  output logic nDTACK,
  output logic nVPA,
  output logic AINACT,
  output logic BACT,
  output logic CACT
);
  logic as, dtack, vpa;
  assign as = ~nAS;
  // phase tracking and sticky acknowledge latches, cleared by the first high sample of nAS
  always_ff @(posedge FCLK) begin
    if (RST) begin
      BACT   <= 1'b0;
      CACT   <= 1'b0;
      AINACT <= 1'b1;
      dtack  <= 1'b0;
      vpa    <= 1'b0;
    end else begin
      BACT   <= as;
      CACT   <= as & BACT;
      AINACT <= ~as & ~BACT;
      dtack  <= as & (dtack | (CACT & Ready & ~IACS));
      vpa    <= as & (vpa | (CACT & Ready & IACS));
    end
  end
  // live nAS gating lets the acknowledge negate as soon as the strobe rises
  assign nDTACK = ~(dtack & as);
  assign nVPA   = ~(vpa & as);
endmodule

// File: tb/tb_fsb_cycle_ctrl.sv
// tb_fsb_cycle_ctrl: table-driven scoreboard bench for the bus cycle controller
module tb_fsb_cycle_ctrl;
  logic FCLK = 1'b0, RST = 1'b1, nAS = 1'b1, Ready = 1'b0, IACS = 1'b0;
  logic nDTACK, nVPA, AINACT, BACT, CACT;
  int vectors = 0, miscompares = 0;

  typedef struct packed {
    logic       rst, nas, ready, iacs;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  fsb_cycle_ctrl dut (
    .FCLK(FCLK), .RST(RST), .nAS(nAS), .Ready(Ready), .IACS(IACS),
    .nDTACK(nDTACK), .nVPA(nVPA), .AINACT(AINACT), .BACT(BACT), .CACT(CACT)
  );

  always #5 FCLK = ~FCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(logic r, logic n, logic rd, logic ic, logic [4:0] e);
    vec_t v;
    v.rst = r; v.nas = n; v.ready = rd; v.iacs = ic; v.exp = e;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    logic [4:0] got;
    @(negedge FCLK);
    RST = v.rst; nAS = v.nas; Ready = v.ready; IACS = v.iacs;
    sb.push_back(v);
    if (v.nas) begin
      #1;
      vectors++;
      if ({nDTACK, nVPA} !== 2'b11) begin
        miscompares++;
        $display("FAIL ack_negate vec %0d: {nDTACK,nVPA}=%b required 11", idx, {nDTACK, nVPA});
      end
    end
    @(posedge FCLK);
    #1;
    e = sb.pop_front();
    got = {BACT, CACT, AINACT, nDTACK, nVPA};
    vectors++;
    if (got !== e.exp) begin
      miscompares++;
      $display("FAIL edge vec %0d: {BACT,CACT,AINACT,nDTACK,nVPA}=%b required %b", idx, got, e.exp);
    end
  endtask

  initial begin
    // expected order {BACT,CACT,AINACT,nDTACK,nVPA}
    tbl.push_back(mk(1,1,0,0,5'b00111));
    tbl.push_back(mk(1,1,0,0,5'b00111));
    tbl.push_back(mk(0,0,1,0,5'b10011));
    tbl.push_back(mk(0,0,1,0,5'b11011));
    tbl.push_back(mk(0,0,1,0,5'b11001));
    tbl.push_back(mk(0,0,1,0,5'b11001));
    tbl.push_back(mk(0,1,1,0,5'b00011));
    tbl.push_back(mk(0,1,1,0,5'b00111));
    tbl.push_back(mk(0,0,1,1,5'b10011));
    tbl.push_back(mk(0,0,1,1,5'b11011));
    tbl.push_back(mk(0,0,1,1,5'b11010));
    tbl.push_back(mk(0,0,1,1,5'b11010));
    tbl.push_back(mk(0,1,1,1,5'b00011));
    tbl.push_back(mk(0,1,1,1,5'b00111));
    tbl.push_back(mk(0,0,0,0,5'b10011));
    tbl.push_back(mk(0,0,0,0,5'b11011));
    tbl.push_back(mk(0,0,0,0,5'b11011));
    tbl.push_back(mk(0,0,1,0,5'b11001));
    tbl.push_back(mk(0,0,0,0,5'b11001));
    tbl.push_back(mk(0,0,0,1,5'b11001));
    tbl.push_back(mk(0,1,0,0,5'b00011));
    tbl.push_back(mk(0,0,1,0,5'b10011));
    tbl.push_back(mk(0,0,1,0,5'b11011));
    tbl.push_back(mk(0,0,1,0,5'b11001));
    tbl.push_back(mk(0,1,1,0,5'b00011));
    tbl.push_back(mk(0,0,1,0,5'b10011));
    tbl.push_back(mk(0,0,1,0,5'b11011));
    tbl.push_back(mk(0,0,1,0,5'b11001));
    tbl.push_back(mk(0,1,1,0,5'b00011));
    tbl.push_back(mk(0,1,1,0,5'b00111));
    tbl.push_back(mk(0,0,1,0,5'b10011));
    tbl.push_back(mk(1,0,1,0,5'b00111));
    tbl.push_back(mk(0,0,1,0,5'b10011));
    tbl.push_back(mk(0,0,1,0,5'b11011));
    tbl.push_back(mk(0,0,1,0,5'b11001));
    tbl.push_back(mk(0,1,1,0,5'b00011));
    tbl.push_back(mk(0,1,1,0,5'b00111));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    // long-stretched interrupt-acknowledge cycle: Ready held low for several edges
    apply(mk(0,0,0,1,5'b10011), 100);
    apply(mk(0,0,0,1,5'b11011), 101);
    for (int i = 0; i < 4; i++) apply(mk(0,0,0,1,5'b11011), 102 + i);
    apply(mk(0,0,1,1,5'b11010), 106);
    apply(mk(0,0,0,0,5'b11010), 107);
    apply(mk(0,1,0,0,5'b00011), 108);
    apply(mk(0,1,0,0,5'b00111), 109);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
